// File: rtl/quickq_deq_ctrl.sv
// Dequeue controller for the QuickQ sorted priority queue: returns the head entry
// and shifts the remaining entries down one address so the queue stays contiguous.
module quickq_deq_ctrl #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          deq,
  input  logic          enq,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          deq_valid,
  output logic [DW-1:0] deq_data,
  output logic          deq_empty
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [DW-1:0] SENT  = {DW{1'b1}};
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_HEAD,
    WAIT_HEAD,
    RD_NEXT,
    WR_SHIFT,
    CLR_LAST,
    RESP
  } state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] i_reg, i_next;
  logic [AW-1:0] i_inc;
  logic [DW-1:0] data_reg, data_next;
  logic          empty_reg, empty_next;

  // i never exceeds DEPTH-2 while shifting, so this increment cannot wrap
  assign i_inc = i_reg + AW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      data_reg  <= '0;
      empty_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      data_reg  <= data_next;
      empty_reg <= empty_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    data_next  = data_reg;
    empty_next = empty_reg;
    ram_addr   = '0;
    ram_wdata  = '0;
    ram_we     = 1'b0;
    deq_valid  = 1'b0;
    deq_empty  = 1'b0;

    case (state_reg)
      IDLE: begin
        // dequeue takes priority when both requests arrive together
        if (deq) begin
          state_next = RD_HEAD;
        end else if (enq) begin
          state_next = IDLE;
        end
      end

      RD_HEAD: begin
        ram_addr   = '0;
        state_next = WAIT_HEAD;
      end

      WAIT_HEAD: begin
        if (ram_rdata == SENT) begin
          empty_next = 1'b1;
          state_next = RESP;
        end else begin
          data_next  = ram_rdata;
          empty_next = 1'b0;
          i_next     = '0;
          state_next = RD_NEXT;
        end
      end

      RD_NEXT: begin
        ram_addr   = i_inc;
        state_next = WR_SHIFT;
      end

      WR_SHIFT: begin
        ram_we    = 1'b1;
        ram_addr  = i_reg;
        ram_wdata = ram_rdata;
        if (ram_rdata == SENT) begin
          state_next = RESP;
        end else if (i_inc == LAST) begin
          state_next = CLR_LAST;
        end else begin
          i_next     = i_inc;
          state_next = RD_NEXT;
        end
      end

      CLR_LAST: begin
        // full queue: nothing shifted into the top slot, so terminate it explicitly
        ram_we     = 1'b1;
        ram_addr   = LAST;
        ram_wdata  = SENT;
        state_next = RESP;
      end

      RESP: begin
        deq_valid  = 1'b1;
        deq_empty  = empty_reg;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy     = (state_reg != IDLE);
  assign deq_data = data_reg;

endmodule
